spi_slave_stream: RTL and testbench
===================================

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 Parameter WORD_W, 8, SPI frame length in bits (4..32).
REQ-002 Parameter CPOL, 0, idle level of SCK.
REQ-003 Parameter CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-004 Parameter FIFO_DEPTH, 4, transmit FIFO entries (power of two, >= 2).
REQ-005 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 spi_sck, spi_cs, spi_mosi  in  1 each  raw SPI pins; CS is active low.
REQ-008 spi_miso  out  1  MSB-first serial data; high-Z while CS is inactive.
REQ-009 tx_data / tx_valid / tx_ready  in WORD_W / in 1 / out 1  transmit FIFO push handshake.
REQ-010 default_word  in  WORD_W  frame sent when the FIFO is empty at load.
REQ-011 tx_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-012 rx_word / rx_valid  out WORD_W / out 1  received frame and one-cycle strobe.
REQ-013 underrun  out  1  one-cycle pulse when default_word is loaded.
REQ-014 frame_active  out  1  synchronised CS is active.
REQ-015 underrun_count  out  8  saturating underrun counter (see Configuration).

Function
REQ-016 SCK and CS SHALL pass through 3-flop synchronisers; MOSI SHALL pass through a 2-flop synchroniser; edges SHALL be detected on flops [2:1].
REQ-017 Leading edge SHALL be the rising edge when CPOL=0 and the falling edge when CPOL=1; sample edge = leading when CPHA=0, trailing when CPHA=1; shift edge = the other edge.
REQ-018 Edges SHALL be ignored while synchronised CS is high.
REQ-019 bitcnt (modulo WORD_W) SHALL clear while CS is inactive and increment on each sample edge.
REQ-020 On each sample edge, synchronised MOSI SHALL shift into the receive register LSB.
REQ-021 On the sample edge where bitcnt=WORD_W-1, rx_word SHALL update the next cycle with rx_valid high for exactly 1 cycle.
REQ-022 Transmit load SHALL occur on a shift edge with bitcnt=0, and additionally on the CS-assert cycle when CPHA=0.
REQ-023 On any other shift edge, the transmit register SHALL shift left, inserting 0; spi_miso = transmit register MSB.
REQ-024 At load, a non-empty FIFO SHALL pop its head into the transmit register; an empty FIFO SHALL load default_word and pulse underrun.
REQ-025 tx_ready = !full; a push SHALL occur when tx_valid && tx_ready.
REQ-026 Push and pop in the same cycle on an empty FIFO: the pop sees empty (default_word is sent) and the pushed word is stored; tx_level becomes 1.
REQ-027 Push and pop in the same cycle on a non-empty, non-full FIFO: tx_level is unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-028 CS deassertion mid-frame SHALL discard the partial receive frame (no rx_valid) and reset bitcnt; an already-popped word is lost, with no re-queue.

Reset
REQ-029 Reset SHALL flush the FIFO (tx_level=0, tx_ready=1) and set rx_word=0, rx_valid=0, underrun=0, bitcnt=0, transmit register=0, underrun_count=0.
REQ-030 Reset SHALL load synchroniser flops with CS=1, SCK=CPOL and MOSI=0; frame_active=0 after reset.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the next frame starts only after a fresh CS falling edge.

Configuration
REQ-032 With macro SPI_SLAVE_STREAM_UNDERRUN_CNT_EN defined, underrun_count SHALL increment on each underrun pulse and saturate at 255.
REQ-033 Without the macro, underrun_count SHALL be tied to 0 and the counter logic SHALL not be built; all other behaviour is identical.

Verification
REQ-034 CPOL=0, CPHA=0, FIFO holds 0xA5; master clocks 0x3C in one frame -> MISO bits 1,0,1,0,0,1,0,1; rx_word=0x3C with one rx_valid pulse; tx_level 1->0.
REQ-035 CPOL=1, CPHA=1, WORD_W=16, FIFO holds 0x1234, 0xBEEF; two frames -> MISO 0x1234 then 0xBEEF; underrun never pulses.
REQ-036 FIFO empty, default_word=0xFF, 3 frames -> MISO 0xFF three times; 3 underrun pulses; underrun_count=3 with macro, 0 without.
REQ-037 Push 5 words with FIFO_DEPTH=4 -> tx_ready low after the 4th push; 5th word held until a pop; tx_level never exceeds 4.
REQ-038 CS raised after 3 bits -> no rx_valid, bitcnt=0; next frame received correctly. Reset pulsed mid-frame -> all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/spi_slave_stream.sv
// SPI slave with a transmit FIFO and a received-word strobe, all logic on sys_clk.
// Defining SPI_SLAVE_STREAM_UNDERRUN_CNT_EN builds a saturating underrun counter.
module spi_slave_stream #(
  parameter int WORD_W     = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          spi_sck,
  input  logic                          spi_cs,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  input  logic [WORD_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [WORD_W-1:0]             default_word,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [WORD_W-1:0]             rx_word,
  output logic                          rx_valid,
  output logic                          underrun,
  output logic                          frame_active,
  output logic [7:0]                    underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(WORD_W);

  logic [2:0]        sck_sync, cs_sync;
  logic [1:0]        mosi_sync, arm_sync;
  logic              armed_reg;
  logic [BW-1:0]     bitcnt_reg;
  logic [WORD_W-1:0] rx_shift_reg, tx_shift_reg;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg;

  // arm_sync marks when cs_sync holds genuine pin samples; armed_reg then waits
  // for CS to be seen idle so a reset during an active frame cannot fake a CS edge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sck_sync  <= {3{CPOL}};
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
      arm_sync  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      cs_sync   <= {cs_sync[1:0], spi_cs};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      arm_sync  <= {arm_sync[0], 1'b1};
      if (arm_sync[1] && cs_sync[1])
        armed_reg <= 1'b1;
    end
  end

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, cs_assert, load, last_bit;
  logic empty, full, push, pop;

  assign sck_rise     = sck_sync[1] & ~sck_sync[2];
  assign sck_fall     = ~sck_sync[1] & sck_sync[2];
  assign lead_edge    = CPOL ? sck_fall : sck_rise;
  assign trail_edge   = CPOL ? sck_rise : sck_fall;
  assign frame_active = armed_reg & ~cs_sync[1];
  assign cs_assert    = armed_reg & cs_sync[2] & ~cs_sync[1];
  assign sample_edge  = frame_active & (CPHA ? trail_edge : lead_edge);
  assign shift_edge   = frame_active & (CPHA ? lead_edge : trail_edge);
  assign last_bit     = (bitcnt_reg == BW'(WORD_W - 1));
  assign load         = (shift_edge && bitcnt_reg == '0) || (!CPHA && cs_assert);

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign pop      = load && !empty;
  assign tx_level = count_reg;
  assign spi_miso = frame_active ? tx_shift_reg[WORD_W-1] : 1'bz;

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // The popped word lives only in the shift register; a CS abort simply drops it.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_shift_reg <= '0;
      underrun     <= 1'b0;
    end else begin
      underrun <= load && empty;
      if (load)
        tx_shift_reg <= empty ? default_word : mem[rd_ptr_reg];
      else if (shift_edge)
        tx_shift_reg <= {tx_shift_reg[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bitcnt_reg   <= '0;
      rx_shift_reg <= '0;
      rx_word      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!frame_active) begin
        bitcnt_reg <= '0;
      end else if (sample_edge) begin
        bitcnt_reg   <= last_bit ? '0 : bitcnt_reg + 1'b1;
        rx_shift_reg <= {rx_shift_reg[WORD_W-2:0], mosi_sync[1]};
        if (last_bit) begin
          rx_word  <= {rx_shift_reg[WORD_W-2:0], mosi_sync[1]};
          rx_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_STREAM_UNDERRUN_CNT_EN
  logic [7:0] urun_cnt_reg;
  always_ff @(posedge sys_clk) begin
    if (reset)
      urun_cnt_reg <= 8'd0;
    else if (underrun && urun_cnt_reg != 8'hFF)
      urun_cnt_reg <= urun_cnt_reg + 8'd1;
  end
  assign underrun_count = urun_cnt_reg;
`else
  assign underrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench: a mode-0 8-bit instance and a mode-3 16-bit instance driven as an SPI master.
module tb_spi_slave_stream;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic sck0, cs0, mosi0, tx_valid0, rdy0, rxv0, urun0, fa0;
  wire  miso0;
  logic [7:0] tx_data0, def0, rxw0, ucnt0;
  logic [2:0] lvl0;

  logic sck3, cs3, mosi3, tx_valid3, rdy3, rxv3, urun3, fa3;
  wire  miso3;
  logic [15:0] tx_data3, def3, rxw3;
  logic [7:0] ucnt3;
  logic [2:0] lvl3;

  spi_slave_stream u0 (
    .sys_clk(clk), .reset(reset), .spi_sck(sck0), .spi_cs(cs0), .spi_mosi(mosi0),
    .spi_miso(miso0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(rdy0),
    .default_word(def0), .tx_level(lvl0), .rx_word(rxw0), .rx_valid(rxv0),
    .underrun(urun0), .frame_active(fa0), .underrun_count(ucnt0));

  spi_slave_stream #(.WORD_W(16), .CPOL(1'b1), .CPHA(1'b1), .FIFO_DEPTH(4)) u3 (
    .sys_clk(clk), .reset(reset), .spi_sck(sck3), .spi_cs(cs3), .spi_mosi(mosi3),
    .spi_miso(miso3), .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(rdy3),
    .default_word(def3), .tx_level(lvl3), .rx_word(rxw3), .rx_valid(rxv3),
    .underrun(urun3), .frame_active(fa3), .underrun_count(ucnt3));

  int vecs = 0;
  int errs = 0;
  int rxc0 = 0, rxc3 = 0, urc0 = 0, urc3 = 0, maxlvl0 = 0;

  always @(posedge clk) begin
    if (rxv0) rxc0 <= rxc0 + 1;
    if (rxv3) rxc3 <= rxc3 + 1;
    if (urun0) urc0 <= urc0 + 1;
    if (urun3) urc3 <= urc3 + 1;
    if (int'(lvl0) > maxlvl0) maxlvl0 <= int'(lvl0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    tx_data0 = d; tx_valid0 = 1'b1; cyc(1); tx_valid0 = 1'b0;
  endtask

  task automatic push3(input logic [15:0] d);
    tx_data3 = d; tx_valid3 = 1'b1; cyc(1); tx_valid3 = 1'b0;
  endtask

  // Mode 0: data changes while SCK is low, master samples MISO just before each rise.
  task automatic bits0(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      mosi0 = mo[7-i]; cyc(8);
      mi[7-i] = miso0; sck0 = 1'b1; cyc(8);
      sck0 = 1'b0;
    end
  endtask

  task automatic frame0(input logic [7:0] mo, output logic [7:0] mi);
    cs0 = 1'b0; cyc(8);
    bits0(mo, 8, mi);
    cyc(8); cs0 = 1'b1; cyc(8);
  endtask

  // Mode 3: SCK idles high, falling edge shifts, master samples just before each rise.
  task automatic frame3(input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    cs3 = 1'b0; cyc(8);
    for (int i = 15; i >= 0; i--) begin
      sck3 = 1'b0; mosi3 = mo[i]; cyc(8);
      mi[i] = miso3; sck3 = 1'b1; cyc(8);
    end
    cs3 = 1'b1; cyc(8);
  endtask

  logic [7:0]  mi0, tmp0;
  logic [15:0] mi3;
  logic [7:0]  exp_ucnt3;

  initial begin
`ifdef SPI_SLAVE_STREAM_UNDERRUN_CNT_EN
    exp_ucnt3 = 8'd3;
`else
    exp_ucnt3 = 8'd0;
`endif
    reset = 1'b1;
    sck0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = '0; def0 = 8'hFF;
    sck3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0; tx_valid3 = 1'b0; tx_data3 = '0; def3 = 16'h00FF;
    cyc(4);
    reset = 1'b0;
    cyc(6);

    chk("rst_lvl0", lvl0, 0);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_rxv0", rxv0, 0);
    chk("rst_urun0", urun0, 0);
    chk("rst_rxw0", rxw0, 0);
    chk("rst_fa0", fa0, 0);
    chk("rst_ucnt0", ucnt0, 0);
    chk("rst_lvl3", lvl3, 0);
    chk("rst_rdy3", rdy3, 1);
    chk("rst_fa3", fa3, 0);

    // Mode 0 single frame: FIFO word A5 out, 3C in.
    push0(8'hA5);
    chk("m0_lvl_pre", lvl0, 1);
    frame0(8'h3C, mi0);
    chk("m0_miso", mi0, 8'hA5);
    chk("m0_rxw", rxw0, 8'h3C);
    chk("m0_rxcnt", rxc0, 1);
    chk("m0_lvl_post", lvl0, 0);
    chk("m0_urun_end", urc0, 1);

    // Mode 3, 16-bit: two queued words, no underrun.
    push3(16'h1234);
    push3(16'hBEEF);
    chk("m3_lvl_pre", lvl3, 2);
    frame3(16'h0F0F, mi3);
    chk("m3_miso1", mi3, 16'h1234);
    chk("m3_rxw1", rxw3, 16'h0F0F);
    frame3(16'hA0C3, mi3);
    chk("m3_miso2", mi3, 16'hBEEF);
    chk("m3_rxw2", rxw3, 16'hA0C3);
    chk("m3_rxcnt", rxc3, 2);
    chk("m3_urun_none", urc3, 0);
    chk("m3_lvl_post", lvl3, 0);

    // Empty FIFO: default word three times.
    for (int k = 0; k < 3; k++) begin
      frame3(16'h5500 + 16'(k), mi3);
      chk("m3_dflt_miso", mi3, 16'h00FF);
    end
    chk("m3_dflt_rxw", rxw3, 16'h5502);
    chk("m3_urun3", urc3, 3);
    chk("m3_ucnt", ucnt3, exp_ucnt3);

    // Fill the 4-deep FIFO and hold a 5th word against backpressure.
    tx_valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data0 = 8'h10 + 8'(k);
      cyc(1);
    end
    chk("full_lvl", lvl0, 4);
    chk("full_rdy", rdy0, 0);
    tx_data0 = 8'h14;
    cyc(5);
    chk("full_hold_lvl", lvl0, 4);
    tx_valid0 = 1'b0;
    def0 = 8'hC3;
    frame0(8'h81, mi0);
    chk("fifo_miso1", mi0, 8'h10);
    chk("fifo_lvl1", lvl0, 2);
    push0(8'h14);
    chk("fifo_lvl_push", lvl0, 3);
    frame0(8'h42, mi0);
    chk("fifo_miso2", mi0, 8'h12);
    chk("fifo_lvl2", lvl0, 1);
    frame0(8'hE7, mi0);
    chk("fifo_miso3", mi0, 8'h14);
    chk("fifo_lvl3", lvl0, 0);
    chk("fifo_rxw", rxw0, 8'hE7);
    chk("fifo_maxlvl", maxlvl0, 4);
    chk("fifo_urun", urc0, 2);

    // CS raised after 3 bits, then a clean frame.
    cs0 = 1'b0; cyc(8);
    chk("part_fa", fa0, 1);
    bits0(8'hE0, 3, tmp0);
    cyc(8); cs0 = 1'b1; cyc(10);
    chk("part_no_rxv", rxc0, 4);
    chk("part_fa_off", fa0, 0);
    frame0(8'h5A, mi0);
    chk("part_next_miso", mi0, 8'hC3);
    chk("part_next_rxw", rxw0, 8'h5A);
    chk("part_next_rxcnt", rxc0, 5);

    // Reset in the middle of a frame while CS stays low.
    push0(8'h77);
    cs0 = 1'b0; cyc(8);
    bits0(8'hF0, 4, tmp0);
    reset = 1'b1; cyc(2);
    chk("mrst_lvl", lvl0, 0);
    chk("mrst_rdy", rdy0, 1);
    chk("mrst_rxv", rxv0, 0);
    chk("mrst_urun", urun0, 0);
    chk("mrst_rxw", rxw0, 0);
    chk("mrst_fa", fa0, 0);
    chk("mrst_ucnt", ucnt0, 0);
    reset = 1'b0;
    bits0(8'hAA, 8, tmp0);
    cyc(6);
    chk("mrst_fa_held", fa0, 0);
    chk("mrst_no_rxv", rxc0, 5);
    cs0 = 1'b1; cyc(8);
    frame0(8'h66, mi0);
    chk("mrst_next_miso", mi0, 8'hC3);
    chk("mrst_next_rxw", rxw0, 8'h66);
    chk("mrst_next_rxcnt", rxc0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
